array_26_req_ctrl: RTL and testbench

//  Requester-side controller for the 8192x42 single-port array macro (RW0 port: addr/en/wmode/wmask/wdata, rdata).

---
 rtl/array_26_ctrl_pkg.sv | 31 +++
 rtl/array_26_resp_queue.sv | 53 +++++
 rtl/array_26_req_ctrl.sv | 169 ++++++++++++++++
 tb/tb_array_26_req_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/array_26_ctrl_pkg.sv
// Shared constants and types for the array_26 requester-side controller.
package array_26_ctrl_pkg;

  localparam int ADDR_W = 13;
  localparam int DEPTH  = 8192;
  localparam int DATA_W = 42;
  localparam int GRAN_W = 7;
  localparam int MASK_W = DATA_W / GRAN_W;

  // Controller phase: clearing sweep after reset, then normal traffic.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

  // Which channel wins the next contested cycle.
  typedef enum logic {
    PTR_W = 1'b0,
    PTR_R = 1'b1
  } rr_ptr_e;

  // One cycle's drive of the macro RW port.
  typedef struct packed {
    logic              en;
    logic              wmode;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] addr;
  } rw_cmd_t;

endpackage

// File: rtl/array_26_resp_queue.sv
// Two-entry FIFO holding read responses that could not be handed straight
// to the consumer. Push and pop may happen in the same cycle.
module array_26_resp_queue
  import array_26_ctrl_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              push_en;
  logic              pop_en;

  // Ignore pops when empty and pushes when full (unless a pop frees a slot).
  assign pop_en  = pop && (count_q != 2'd0);
  assign push_en = push && ((count_q != 2'd2) || pop_en);

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_en) wr_ptr_q <= ~wr_ptr_q;
      if (pop_en)  rd_ptr_q <= ~rd_ptr_q;
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage.
  // NOTE: storage words are not reset; count and pointers qualify every read, so stale words are never presented.
  always_ff @(posedge clock) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/array_26_req_ctrl.sv
// Requester-side controller for the 8192x42 single-port array macro.
// Clears the array after reset, then arbitrates a write channel and a read
// channel onto the single RW0 port and returns read data in request order.
module array_26_req_ctrl
  import array_26_ctrl_pkg::*;
#(
  parameter bit                INIT_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VALUE    = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_w_valid,
  output logic              io_w_ready,
  input  logic [ADDR_W-1:0] io_w_addr,
  input  logic [DATA_W-1:0] io_w_data,
  input  logic [MASK_W-1:0] io_w_mask,
  input  logic              io_r_req_valid,
  output logic              io_r_req_ready,
  input  logic [ADDR_W-1:0] io_r_req_addr,
  output logic              io_r_resp_valid,
  input  logic              io_r_resp_ready,
  output logic [DATA_W-1:0] io_r_resp_data,
  output logic              io_init_done,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  rr_ptr_e           rr_q, rr_d;
  logic              init_done_q;
  logic              s1_valid_q;

  logic              w_port_req;
  logic              r_port_req;
  logic              w_drop;
  logic              grant_w;
  logic              grant_r;
  rw_cmd_t           cmd;

  logic [1:0]        q_count;
  logic [DATA_W-1:0] q_head;
  logic              q_push;
  logic              q_pop;
  logic [2:0]        inflight;
  logic              read_credit;

  // A read may only issue if its response is guaranteed a slot: the queue
  // occupancy plus the read already in the macro must leave room.
  assign inflight    = {1'b0, q_count} + {2'b00, s1_valid_q};
  assign read_credit = (inflight < 3'd2);

  // Sweep/run sequencing, arbitration and RW0 command selection.
  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_d       = rr_q;
    grant_w    = 1'b0;
    grant_r    = 1'b0;
    w_drop     = 1'b0;
    cmd        = '0;
    w_port_req = io_w_valid && (io_w_mask != '0);
    r_port_req = io_r_req_valid && read_credit;

    case (state_q)
      INIT: begin
        cmd.en    = 1'b1;
        cmd.wmode = 1'b1;
        cmd.wmask = '1;
        cmd.wdata = INIT_VALUE;
        cmd.addr  = cnt_q;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // A fully masked write changes nothing, so it is acknowledged
        // without occupying the port.
        w_drop = io_w_valid && (io_w_mask == '0);
        if (w_port_req && r_port_req) begin
          grant_w = (rr_q == PTR_W);
          grant_r = !grant_w;
          rr_d    = grant_w ? PTR_R : PTR_W;
        end else begin
          grant_w = w_port_req;
          grant_r = r_port_req;
        end

        if (grant_w) begin
          cmd.en    = 1'b1;
          cmd.wmode = 1'b1;
          cmd.wmask = io_w_mask;
          cmd.wdata = io_w_data;
          cmd.addr  = io_w_addr;
        end else if (grant_r) begin
          cmd.en    = 1'b1;
          cmd.addr  = io_r_req_addr;
        end
      end
      default: state_d = INIT;
    endcase
  end

  // Read data is only valid for the single cycle after issue; hand it to the
  // consumer directly when nothing older is waiting, otherwise park it.
  always_comb begin
    q_push          = 1'b0;
    q_pop           = 1'b0;
    io_r_resp_valid = 1'b0;
    io_r_resp_data  = '0;
    if (q_count != 2'd0) begin
      io_r_resp_valid = 1'b1;
      io_r_resp_data  = q_head;
      q_pop           = io_r_resp_ready;
      q_push          = s1_valid_q;
    end else if (s1_valid_q) begin
      io_r_resp_valid = 1'b1;
      io_r_resp_data  = RW0_rdata;
      q_push          = !io_r_resp_ready;
    end
  end

  // Control state: phase, sweep address, arbitration pointer, read in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= INIT_ON_RESET ? INIT : RUN;
      cnt_q       <= '0;
      rr_q        <= PTR_W;
      init_done_q <= 1'b0;
      s1_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      init_done_q <= (state_d == RUN);
      s1_valid_q  <= grant_r;
    end
  end

  array_26_resp_queue u_resp_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (q_push),
    .push_data (RW0_rdata),
    .pop       (q_pop),
    .head_data (q_head),
    .count     (q_count)
  );

  assign io_w_ready     = grant_w || w_drop;
  assign io_r_req_ready = grant_r;
  assign io_init_done   = init_done_q;

  assign RW0_en    = cmd.en;
  assign RW0_wmode = cmd.wmode;
  assign RW0_wmask = cmd.wmask;
  assign RW0_wdata = cmd.wdata;
  assign RW0_addr  = cmd.addr;

endmodule

// File: tb/tb_array_26_req_ctrl.sv
// Scoreboard bench for array_26_req_ctrl with a behavioural macro model and
// a high-level reference of the array contents and arbitration rules.
module tb_array_26_req_ctrl;

  localparam int ADDR_W = 13;
  localparam int DEPTH  = 8192;
  localparam int DATA_W = 42;
  localparam int MASK_W = 6;
  localparam int GRAN_W = 7;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              w_valid = 1'b0;
  logic [ADDR_W-1:0] w_addr = '0;
  logic [DATA_W-1:0] w_data = '0;
  logic [MASK_W-1:0] w_mask = '0;
  logic              r_req_valid = 1'b0;
  logic [ADDR_W-1:0] r_req_addr = '0;
  logic              r_resp_ready = 1'b1;

  logic              io_w_ready, io_r_req_ready, io_r_resp_valid, io_init_done;
  logic [DATA_W-1:0] io_r_resp_data;
  logic [ADDR_W-1:0] rw0_addr;
  logic              rw0_en, rw0_wmode;
  logic [MASK_W-1:0] rw0_wmask;
  logic [DATA_W-1:0] rw0_wdata, rw0_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  array_26_req_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .io_w_valid      (w_valid),
    .io_w_ready      (io_w_ready),
    .io_w_addr       (w_addr),
    .io_w_data       (w_data),
    .io_w_mask       (w_mask),
    .io_r_req_valid  (r_req_valid),
    .io_r_req_ready  (io_r_req_ready),
    .io_r_req_addr   (r_req_addr),
    .io_r_resp_valid (io_r_resp_valid),
    .io_r_resp_ready (r_resp_ready),
    .io_r_resp_data  (io_r_resp_data),
    .io_init_done    (io_init_done),
    .RW0_addr        (rw0_addr),
    .RW0_en          (rw0_en),
    .RW0_wmode       (rw0_wmode),
    .RW0_wmask       (rw0_wmask),
    .RW0_wdata       (rw0_wdata),
    .RW0_rdata       (rw0_rdata)
  );

  // Macro model: masked writes at the edge; read output tracks the last read
  // address, so it follows later writes to that address.
  logic [DATA_W-1:0] mac_mem [0:DEPTH-1];
  logic [ADDR_W-1:0] mac_raddr = '0;
  always @(posedge clock) begin
    if (rw0_en) begin
      if (rw0_wmode) begin
        for (int g = 0; g < MASK_W; g++)
          if (rw0_wmask[g]) mac_mem[rw0_addr][g*GRAN_W +: GRAN_W] <= rw0_wdata[g*GRAN_W +: GRAN_W];
      end else begin
        mac_raddr <= rw0_addr;
      end
    end
  end
  assign rw0_rdata = mac_mem[mac_raddr];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state.
  logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
  logic [DATA_W-1:0] exp_q [$];
  int outstanding = 0;
  bit rr_w = 1'b1;
  int sweep_cnt = 0;

  // Monitor: predicts grants and port drive, scores responses against the queue.
  always @(negedge clock) begin
    bit w_port, r_elig, gw, gr;
    logic [62:0] exp_cmd;
    if (reset) begin
      exp_q.delete();
      outstanding = 0;
      rr_w = 1'b1;
      sweep_cnt = 0;
    end else if (sweep_cnt < DEPTH) begin
      check("sweep",
            128'({rw0_en, rw0_wmode, rw0_wmask, rw0_wdata, rw0_addr,
                  io_w_ready, io_r_req_ready, io_r_resp_valid, io_init_done}),
            128'({1'b1, 1'b1, 6'h3f, 42'h0, 13'(sweep_cnt), 4'b0000}));
      sweep_cnt++;
      if (sweep_cnt == DEPTH)
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    end else begin
      w_port = w_valid && (w_mask != '0);
      r_elig = r_req_valid && (outstanding < 2);
      gw = w_port && (!r_elig || rr_w);
      gr = r_elig && (!w_port || !rr_w);
      check("init_done", 128'(io_init_done), 128'(1));
      check("w_ready", 128'(io_w_ready), 128'(gw || (w_valid && w_mask == '0)));
      check("r_req_ready", 128'(io_r_req_ready), 128'(gr));
      if (gw)      exp_cmd = {1'b1, 1'b1, w_mask, w_data, w_addr};
      else if (gr) exp_cmd = {1'b1, 1'b0, 6'h0, 42'h0, r_req_addr};
      else         exp_cmd = '0;
      check("rw0_cmd", 128'({rw0_en, rw0_wmode, rw0_wmask, rw0_wdata, rw0_addr}), 128'(exp_cmd));
      check("resp_valid", 128'(io_r_resp_valid), 128'(exp_q.size() != 0));
      if (io_r_resp_valid && exp_q.size() != 0) begin
        check("resp_data", 128'(io_r_resp_data), 128'(exp_q[0]));
        if (r_resp_ready) begin
          void'(exp_q.pop_front());
          outstanding--;
        end
      end
      if (gr) begin
        exp_q.push_back(ref_mem[r_req_addr]);
        outstanding++;
      end
      if (gw)
        for (int g = 0; g < MASK_W; g++)
          if (w_mask[g]) ref_mem[w_addr][g*GRAN_W +: GRAN_W] = w_data[g*GRAN_W +: GRAN_W];
      if (w_port && r_elig) rr_w = !gw;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [MASK_W-1:0] m);
    bit done = 1'b0;
    w_valid = 1'b1; w_addr = a; w_data = d; w_mask = m;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clock);
      done = io_w_ready;
      step();
    end
    w_valid = 1'b0;
    check("write_accepted", 128'(done), 128'(1));
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    bit done = 1'b0;
    r_req_valid = 1'b1; r_req_addr = a;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clock);
      done = io_r_req_ready;
      step();
    end
    r_req_valid = 1'b0;
    check("read_accepted", 128'(done), 128'(1));
  endtask

  task automatic wait_sweep(input string name);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 9000) begin
      @(negedge clock);
      done = io_init_done;
      if (!done) begin
        n++;
        step();
      end
    end
    check(name, 128'(n), 128'(DEPTH));
    step();
  endtask

  task automatic drain();
    w_valid = 1'b0; r_req_valid = 1'b0; r_resp_ready = 1'b1;
    repeat (6) step();
  endtask

  task automatic random_traffic(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      w_valid      = ($urandom_range(0, 1) == 1);
      w_addr       = ($urandom_range(0, 7) == 0) ? 13'h1fff : 13'($urandom_range(0, 15));
      w_data       = {10'($urandom()), $urandom()};
      w_mask       = ($urandom_range(0, 5) == 0) ? 6'h0 : 6'($urandom_range(1, 63));
      r_req_valid  = ($urandom_range(0, 1) == 1);
      r_req_addr   = ($urandom_range(0, 7) == 0) ? 13'h1fff : 13'($urandom_range(0, 15));
      r_resp_ready = ($urandom_range(0, 9) < 7);
      step();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // Clear sweep after reset.
    wait_sweep("init_cycles");

    // Full write then read-back with bypass latency.
    r_resp_ready = 1'b1;
    do_write(13'h005, 42'h2AA_AAAA_AAAA, 6'h3f);
    do_read(13'h005);
    @(negedge clock);
    check("t2_valid", 128'(io_r_resp_valid), 128'(1));
    check("t2_data", 128'(io_r_resp_data), 128'(42'h2AA_AAAA_AAAA));
    step();

    // Single-granule write over a cleared entry.
    do_write(13'h010, '1, 6'b000001);
    do_read(13'h010);
    @(negedge clock);
    check("t3_data", 128'(io_r_resp_data), 128'(42'h000_0000_007F));
    step();
    drain();

    // Both channels held: grants alternate starting with write.
    w_valid = 1'b1; w_addr = 13'h020; w_data = 42'h123; w_mask = 6'h3f;
    r_req_valid = 1'b1; r_req_addr = 13'h021;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check("t4_w_grant", 128'(io_w_ready), 128'(k % 2 == 0));
      check("t4_r_grant", 128'(io_r_req_ready), 128'(k % 2 == 1));
      step();
    end
    // Fully masked write leaves the port to the read.
    w_mask = 6'h0;
    @(negedge clock);
    check("t4_drop_w", 128'(io_w_ready), 128'(1));
    check("t4_drop_r", 128'({io_r_req_ready, rw0_en, rw0_wmode}), 128'(3'b110));
    step();
    r_req_valid = 1'b0;
    @(negedge clock);
    check("t4_drop_idle", 128'({io_w_ready, rw0_en}), 128'(2'b10));
    step();
    drain();

    // Backpressure: two reads accepted, third held until the queue drains.
    do_write(13'h001, 42'h1, 6'h3f);
    do_write(13'h002, 42'h2, 6'h3f);
    do_write(13'h003, 42'h3, 6'h3f);
    r_resp_ready = 1'b0;
    acc = 0;
    r_req_valid = 1'b1; r_req_addr = 13'h001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (io_r_req_ready) acc++;
      step();
      r_req_addr = 13'(acc + 1);
    end
    check("t5_accepted", 128'(acc), 128'(2));
    r_resp_ready = 1'b1;
    @(negedge clock);
    check("t5_d1", 128'({io_r_resp_valid, io_r_resp_data}), 128'({1'b1, 42'h1}));
    check("t5_r3_held", 128'(io_r_req_ready), 128'(0));
    step();
    @(negedge clock);
    check("t5_d2", 128'({io_r_resp_valid, io_r_resp_data}), 128'({1'b1, 42'h2}));
    check("t5_r3_accept", 128'(io_r_req_ready), 128'(1));
    step();
    r_req_valid = 1'b0;
    @(negedge clock);
    check("t5_d3", 128'({io_r_resp_valid, io_r_resp_data}), 128'({1'b1, 42'h3}));
    step();
    drain();

    // Randomised mixed traffic with hazards on a small address set.
    random_traffic(2000);
    drain();
    check("drain1_empty", 128'(exp_q.size()), 128'(0));

    // Reset with one response queued and one in flight.
    r_resp_ready = 1'b0;
    do_read(13'h001);
    r_req_valid = 1'b1; r_req_addr = 13'h002;
    @(negedge clock);
    check("t6_second_read", 128'(io_r_req_ready), 128'(1));
    step();
    reset = 1'b1;
    w_valid = 1'b1; w_addr = 13'h004; w_data = 42'h5; w_mask = 6'h3f;
    step();
    @(negedge clock);
    check("t6_reset_state", 128'({io_r_resp_valid, io_init_done, io_w_ready, io_r_req_ready, rw0_en}),
          128'({5'b00001}));
    step();
    reset = 1'b0;
    // Requests held during the second sweep must not be accepted.
    wait_sweep("init2_cycles");
    w_valid = 1'b0; r_req_valid = 1'b0; r_resp_ready = 1'b1;
    step();

    random_traffic(300);
    drain();
    check("drain2_empty", 128'(exp_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
